ps2_rx_fifo: RTL and testbench

PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

---
 rtl/ps2_rx_pkg.sv | 34 +++
 rtl/ps2_rx_sfifo.sv | 62 ++++++
 rtl/ps2_rx_fifo.sv | 221 ++++++++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_rx_pkg.sv
// Shared definitions for the PS/2 receive FIFO block: frame FSM states,
// CPU register map, status/control bit positions and default parameters.
package ps2_rx_pkg;

  // Frame receiver states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  // CPU register offsets (addr is a single bit)
  localparam logic REG_STATUS = 1'b0;
  localparam logic REG_DATA   = 1'b1;

  // Status / control bit positions in the addr-0 register
  localparam int STAT_RDY   = 0;
  localparam int STAT_OVR   = 1;
  localparam int STAT_PERR  = 2;
  localparam int STAT_FERR  = 3;
  localparam int CTRL_FLUSH = 6;
  localparam int CTRL_IE    = 7;

  // Default parameters
  localparam int DEF_FIFO_DEPTH = 8;
  localparam int DEF_TIMEOUT    = 2000;

  // 2-of-3 majority vote used by the pin glitch filters
  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/ps2_rx_sfifo.sv
// Single-clock receive FIFO with full/empty flags and an occupancy count.
// A push into a full FIFO succeeds only when a pop happens in the same cycle;
// flush empties the FIFO and suppresses any same-cycle push/pop.
module ps2_rx_sfifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // pop of an empty FIFO is ignored; push into a full one needs a real pop
  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  assign do_push = push_i & ~flush_i & (~full_o | do_pop);

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // storage array, no reset needed (guarded by the count)
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 receiver with CPU-readable byte FIFO.
// Pins are synchronised and majority-filtered; a frame FSM assembles
// start/8 data/odd parity/stop frames on filtered clock falls, with a
// watchdog that aborts stalled frames. Optional interrupt output is enabled
// by defining PS2_RX_FIFO_IRQ_EN; without it the irq port does not exist and
// the IE bit reads 0.
module ps2_rx_fifo
  import ps2_rx_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs,
  input  logic       we,
  input  logic       addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       ps2_clk,
  input  logic       ps2_dat
`ifdef PS2_RX_FIFO_IRQ_EN
  ,
  output logic       irq
`endif
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  // ---------------- pin conditioning ----------------
  logic [1:0] clk_sync_q, dat_sync_q;
  logic [2:0] clk_hist_q, dat_hist_q;
  logic       clk_filt_q, clk_prev_q, dat_filt_q;
  logic       fall;

  // two-flop synchronisers feeding 3-sample majority filters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_hist_q <= '1;
      dat_hist_q <= '1;
      clk_filt_q <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_filt_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_dat};
      clk_hist_q <= {clk_hist_q[1:0], clk_sync_q[1]};
      dat_hist_q <= {dat_hist_q[1:0], dat_sync_q[1]};
      clk_filt_q <= maj3(clk_hist_q);
      clk_prev_q <= clk_filt_q;
      dat_filt_q <= maj3(dat_hist_q);
    end
  end

  assign fall = clk_prev_q & ~clk_filt_q;

  // ---------------- frame FSM ----------------
  ps2_state_e  state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic        par_q, par_d;
  logic        push_q, push_d;
  logic        ferr_set, perr_set;
  logic [WD_W-1:0] wdog_q;
  logic        timeout;

  // watchdog expires when a frame stalls TIMEOUT cycles without a fall
  assign timeout = (state_q != ST_IDLE) && !fall && (wdog_q == WD_W'(TIMEOUT - 1));

  // watchdog counter: cleared in IDLE and on every fall
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                    wdog_q <= '0;
    else if (state_q == ST_IDLE || fall || timeout) wdog_q <= '0;
    else                                         wdog_q <= wdog_q + WD_W'(1);
  end

  // state and frame datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      bitcnt_q <= '0;
      par_q    <= 1'b0;
      push_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      par_q    <= par_d;
      push_q   <= push_d;
    end
  end

  // next-state logic; data sampled on each filtered clock fall
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    par_d    = par_q;
    push_d   = 1'b0;
    ferr_set = 1'b0;
    perr_set = 1'b0;
    if (timeout) begin
      state_d  = ST_IDLE;
      ferr_set = 1'b1;
    end else if (fall) begin
      case (state_q)
        ST_IDLE: begin
          if (!dat_filt_q) begin
            state_d  = ST_DATA;
            bitcnt_d = '0;
          end
        end
        ST_DATA: begin
          shift_d  = {dat_filt_q, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          par_d   = dat_filt_q;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (!dat_filt_q)            ferr_set = 1'b1;
          else if (^{par_q, shift_q}) push_d   = 1'b1;
          else                        perr_set = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // ---------------- CPU interface and FIFO ----------------
  logic       rd, rd_data, wr_ctrl, flush;
  logic       fifo_full, fifo_empty;
  logic [7:0] fifo_head;
  logic [$clog2(FIFO_DEPTH):0] fifo_cnt;
  logic       ferr_q, perr_q, ovr_q, ovr_set;
  logic       ie;
  logic [7:0] status, dout_q;

  assign rd      = cs & ~we;
  assign rd_data = rd & (addr == REG_DATA);
  assign wr_ctrl = cs & we & (addr == REG_STATUS);
  assign flush   = wr_ctrl & din[CTRL_FLUSH];

  ps2_rx_sfifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .flush_i (flush),
    .push_i  (push_q),
    .pop_i   (rd_data),
    .wdata_i (shift_q),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  // a push lost to a full FIFO is an overrun; a push lost to flush is not
  assign ovr_set = push_q & fifo_full & ~rd_data & ~flush;

  // sticky error flags: set beats a same-cycle clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ferr_q <= 1'b0;
      perr_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      ferr_q <= ferr_set | (ferr_q & ~(wr_ctrl & din[STAT_FERR]));
      perr_q <= perr_set | (perr_q & ~(wr_ctrl & din[STAT_PERR]));
      ovr_q  <= ovr_set  | (ovr_q  & ~(wr_ctrl & din[STAT_OVR]));
    end
  end

`ifdef PS2_RX_FIFO_IRQ_EN
  logic ie_q, irq_q;

  // interrupt enable and registered interrupt request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ie_q  <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      if (wr_ctrl) ie_q <= din[CTRL_IE];
      irq_q <= ie_q & (~fifo_empty | ovr_q);
    end
  end

  assign ie  = ie_q;
  assign irq = irq_q;

  logic unused_sink;
  assign unused_sink = ^{din[5:4], din[0], fifo_cnt};
`else
  assign ie = 1'b0;

  logic unused_sink;
  assign unused_sink = ^{din[7], din[5:4], din[0], fifo_cnt};
`endif

  assign status = {ie, 3'b000, ferr_q, perr_q, ovr_q, ~fifo_empty};

  // registered read data; data reads of an empty FIFO return zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) dout_q <= 8'h00;
    else if (rd) begin
      if (addr == REG_DATA) dout_q <= fifo_empty ? 8'h00 : fifo_head;
      else                  dout_q <= status;
    end
  end

  assign dout = dout_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Scoreboard bench for ps2_rx_fifo: a PS/2 device model drives frames, a
// queue-based reference model predicts every CPU read, and a monitor compares
// dout after each read edge.
module tb_ps2_rx_fifo;

  localparam int DEPTH = 8;
  localparam int H     = 20;   // PS/2 half bit time in clk cycles

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cs = 1'b0, we = 1'b0, addr = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       ps2_clk = 1'b1, ps2_dat = 1'b1;
`ifdef PS2_RX_FIFO_IRQ_EN
  logic       irq;
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  ps2_rx_fifo #(.FIFO_DEPTH(DEPTH), .TIMEOUT(2000)) dut (
    .clk     (clk),
    .rst     (rst),
    .cs      (cs),
    .we      (we),
    .addr    (addr),
    .din     (din),
    .dout    (dout),
    .ps2_clk (ps2_clk),
    .ps2_dat (ps2_dat)
`ifdef PS2_RX_FIFO_IRQ_EN
    ,
    .irq     (irq)
`endif
  );

  int total = 0;
  int bad   = 0;

  // scoreboard of expected read results
  logic [7:0] exp_q[$];
  string      nm_q[$];

  // reference model of the block's architectural state
  logic [7:0] mq[$];
  bit m_ie, m_ferr, m_perr, m_ovr;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] m_status();
    logic rdy;
    rdy = (mq.size() != 0);
    return {m_ie, 3'b000, m_ferr, m_perr, m_ovr, rdy};
  endfunction

  // monitor: every CPU read edge produces a dout value to score
  initial begin
    forever begin
      @(posedge clk);
      if (rst && cs && !we) begin
        #1;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL monitor: unexpected read dout=%02h expected none", dout);
        end else begin
          check(nm_q.pop_front(), dout, exp_q.pop_front());
        end
      end
    end
  end

  task automatic cpu_read(input logic a, input logic [7:0] e, input string nm);
    @(negedge clk);
    cs = 1'b1; we = 1'b0; addr = a;
    exp_q.push_back(e);
    nm_q.push_back(nm);
    @(negedge clk);
    cs = 1'b0;
  endtask

  task automatic cpu_write(input logic a, input logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; we = 1'b1; addr = a; din = d;
    @(negedge clk);
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic rd_status(input string nm);
    cpu_read(1'b0, m_status(), nm);
  endtask

  task automatic rd_data(input string nm);
    logic [7:0] e;
    if (mq.size() > 0) e = mq.pop_front();
    else               e = 8'h00;
    cpu_read(1'b1, e, nm);
  endtask

  task automatic wr_ctrl(input logic [7:0] d);
    cpu_write(1'b0, d);
    if (IRQ_EN) m_ie = d[7];
    if (d[3]) m_ferr = 1'b0;
    if (d[2]) m_perr = 1'b0;
    if (d[1]) m_ovr  = 1'b0;
    if (d[6]) mq.delete();
  endtask

  // one PS/2 bit: data set while clock high, then a low pulse
  task automatic send_bit(input logic b);
    @(negedge clk);
    ps2_dat = b;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic p;
    p = (~^b) ^ bad_par;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(p);
    send_bit(!bad_stop);
    ps2_dat = 1'b1;
    repeat (10) @(negedge clk);
    if (bad_stop)                  m_ferr = 1'b1;
    else if (bad_par)              m_perr = 1'b1;
    else if (mq.size() < DEPTH)    mq.push_back(b);
    else                           m_ovr = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    mq.delete();
    m_ie = 0; m_ferr = 0; m_perr = 0; m_ovr = 0;
    check("dout in reset", dout, 8'h00);
    rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int k, ops, op;
    logic [7:0] b;

    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("dout at reset", dout, 8'h00);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rd_status("reset status");
    rd_data("reset empty data");

    // basic good frame
    send_frame(8'h1C, 0, 0);
    rd_status("rdy after 1C");
    rd_data("data 1C");
    rd_status("empty after 1C");

    // parity error and clear
    send_frame(8'h5A, 1, 0);
    rd_status("perr 5A");
    wr_ctrl(8'h04);
    rd_status("perr cleared");

    // overrun with depth 8
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 0);
    rd_status("ovr full");
    for (int i = 0; i < 9; i++) rd_data("drain");
    rd_status("ovr after drain");
    wr_ctrl(8'h02);
    rd_status("ovr cleared");

    // stalled frame -> watchdog
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    ps2_dat = 1'b1;
    repeat (2100) @(negedge clk);
    m_ferr = 1'b1;
    rd_status("ferr timeout");
    wr_ctrl(8'h08);
    send_frame(8'h29, 0, 0);
    rd_data("data 29 after timeout");
    rd_status("status after 29");

    // bad stop bit
    send_frame(8'hA5, 0, 1);
    rd_status("ferr bad stop");
    wr_ctrl(8'h0E);
    rd_status("all cleared");

    // write to data address is ignored; flush empties FIFO
    send_frame(8'h3C, 0, 0);
    send_frame(8'hC3, 0, 0);
    cpu_write(1'b1, 8'hFF);
    rd_status("after data write");
    wr_ctrl(8'h40);
    rd_status("flushed");
    rd_data("flushed data");

`ifdef PS2_RX_FIFO_IRQ_EN
    wr_ctrl(8'h80);
    send_frame(8'h76, 0, 0);
    check("irq set", {7'b0, irq}, 8'h01);
    rd_status("ie status");
    rd_data("data 76");
    @(negedge clk);
    check("irq cleared", {7'b0, irq}, 8'h00);
    wr_ctrl(8'h00);
`endif

    // reset during data bit 5 with flags and data present
    send_frame(8'h11, 0, 0);
    send_frame(8'h22, 1, 0);
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    @(negedge clk);
    ps2_dat = 1'b0;
    do_reset();
    ps2_dat = 1'b1;
    repeat (5) @(negedge clk);
    rd_status("after midframe reset");
    send_frame(8'h33, 0, 0);
    rd_data("data 33");
    rd_status("empty after 33");

    // randomized traffic
    for (int n = 0; n < 25; n++) begin
      k = int'($urandom_range(0, 9));
      b = 8'($urandom);
      send_frame(b, k == 7, k == 8);
      ops = int'($urandom_range(0, 4));
      for (int j = 0; j < ops; j++) begin
        op = int'($urandom_range(0, 5));
        case (op)
          0, 1, 2: rd_data("rand data");
          3:       rd_status("rand status");
          4:       wr_ctrl(8'($urandom));
          default: cpu_write(1'b1, 8'($urandom));
        endcase
      end
    end
    while (mq.size() > 0) rd_data("final drain");
    rd_status("final status");

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard drain: pending=%0d expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
